// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter: round-robin arbiter/sequencer sharing one scratchpad
// port between NUM_REQ load/store clients. One request outstanding at a time;
// illegal (out-of-range or misaligned) requests are answered with an error
// without touching the scratchpad.
module scratchpad_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int SCRATCHPAD_BASE = 16,
    parameter int SCRATCHPAD_SIZE = 8,
    parameter int RD_LATENCY      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*64-1:0]  req_addr,
    input  logic [NUM_REQ*2-1:0]   req_len,
    input  logic [NUM_REQ*64-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [63:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   sp_en,
    output logic                   sp_write,
    output logic [63:0]            sp_addr,
    output logic [1:0]             sp_len,
    output logic [63:0]            sp_wdata,
    input  logic [63:0]            sp_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [63:0]        BASE     = 64'(SCRATCHPAD_BASE);
    // one past the last legal byte, kept 65 bits wide so the end-address
    // compare can never wrap
    localparam logic [64:0]        LIMIT    = 65'(SCRATCHPAD_BASE) + 65'(SCRATCHPAD_SIZE);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_idx;
    logic                r_write;
    logic [1:0]          r_len;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_sp_en;
    logic                r_sp_write;
    logic [63:0]         r_sp_addr;
    logic [1:0]          r_sp_len;
    logic [63:0]         r_sp_wdata;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [63:0]         r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_found;
    logic [IDX_W-1:0]    w_gidx;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_xfer;
    logic                w_sel_write;
    logic [63:0]         w_sel_addr;
    logic [1:0]          w_sel_len;
    logic [63:0]         w_sel_wdata;
    logic [64:0]         w_end;
    logic [63:0]         w_align_mask;
    logic                w_legal;
    logic                w_wait_last;

    // First valid requester at or above ptr, wrapping. Scanning from the far
    // end downward lets the closest hit overwrite the others.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        int               j;
        sel = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (v[j]) sel = IDX_W'(j);
        end
        return sel;
    endfunction

    // Zero-extend read data from the access size.
    function automatic logic [63:0] len_mask(input logic [63:0] d, input logic [1:0] len);
        case (len)
            2'b00:   return {56'd0, d[7:0]};
            2'b01:   return {48'd0, d[15:0]};
            2'b10:   return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

    // Round-robin grant; ready is only offered in IDLE and never during reset.
    always_comb begin
        w_found   = |req_valid;
        w_gidx    = rr_pick(req_valid, r_rr_ptr);
        w_grant   = w_found ? (ONE << w_gidx) : '0;
        req_ready = (r_state == S_IDLE && !rst) ? w_grant : '0;
        w_xfer    = (r_state == S_IDLE) && !rst && w_found;
    end

    // Select the granted requester's fields.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gidx == IDX_W'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*64 +: 64];
                w_sel_len   = req_len[i*2 +: 2];
                w_sel_wdata = req_wdata[i*64 +: 64];
            end
        end
    end

    // Range and natural-alignment check on the selected request.
    always_comb begin
        w_end        = {1'b0, w_sel_addr} + (65'd1 << w_sel_len);
        w_align_mask = (64'd1 << w_sel_len) - 64'd1;
        w_legal      = (w_sel_addr >= BASE) && (w_end <= LIMIT) &&
                       ((w_sel_addr & w_align_mask) == 64'd0);
    end

    // Next-state logic.
    always_comb begin
        w_next      = r_state;
        w_wait_last = (r_state == S_WAIT) && (r_cnt == CNT_LAST);
        case (r_state)
            S_IDLE:  if (w_xfer) w_next = w_legal ? S_ISSUE : S_RESP;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == CNT_LAST) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Request latch, round-robin pointer and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_len    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_xfer) begin
                r_idx    <= w_gidx;
                r_write  <= w_sel_write;
                r_len    <= w_sel_len;
                r_rr_ptr <= (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            if (r_state == S_WAIT && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
            else                                        r_cnt <= '0;
        end
    end

    // Scratchpad strobe: registered, live only for the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp_en    <= 1'b0;
            r_sp_write <= 1'b0;
            r_sp_addr  <= '0;
            r_sp_len   <= '0;
            r_sp_wdata <= '0;
        end else if (w_next == S_ISSUE) begin
            r_sp_en    <= 1'b1;
            r_sp_write <= w_sel_write;
            r_sp_addr  <= w_sel_addr;
            r_sp_len   <= w_sel_len;
            r_sp_wdata <= w_sel_wdata;
        end else begin
            r_sp_en    <= 1'b0;
            r_sp_write <= 1'b0;
            r_sp_addr  <= '0;
            r_sp_len   <= '0;
            r_sp_wdata <= '0;
        end
    end

    // Response: read data is captured straight into the response register on
    // the last WAIT edge; errors are answered directly from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_xfer && !w_legal) begin
            r_rsp_valid <= w_grant;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
        end else if (w_wait_last) begin
            r_rsp_valid <= ONE << r_idx;
            r_rsp_rdata <= r_write ? 64'd0 : len_mask(sp_rdata, r_len);
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign sp_en     = r_sp_en;
    assign sp_write  = r_sp_write;
    assign sp_addr   = r_sp_addr;
    assign sp_len    = r_sp_len;
    assign sp_wdata  = r_sp_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter: one instance at RD_LATENCY=1 and one
// at RD_LATENCY=3 sharing request inputs; each is held in reset while the
// other is exercised.
module tb_scratchpad_arbiter;

    logic          clk = 1'b0;
    logic          rst, rst3;
    logic [1:0]    req_valid, req_write;
    logic [127:0]  req_addr, req_wdata;
    logic [3:0]    req_len;
    logic [63:0]   sp_rdata;

    logic [1:0]    ready1, rspv1, ready3, rspv3;
    logic [63:0]   rdata1, spa1, spwd1, rdata3, spa3, spwd3;
    logic          err1, spen1, spw1, err3, spen3, spw3;
    logic [1:0]    spl1, spl3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scratchpad_arbiter #(.NUM_REQ(2), .SCRATCHPAD_BASE(16), .SCRATCHPAD_SIZE(8), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rspv1), .rsp_rdata(rdata1), .rsp_err(err1),
        .sp_en(spen1), .sp_write(spw1), .sp_addr(spa1), .sp_len(spl1), .sp_wdata(spwd1),
        .sp_rdata(sp_rdata));

    scratchpad_arbiter #(.NUM_REQ(2), .SCRATCHPAD_BASE(16), .SCRATCHPAD_SIZE(8), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid), .req_ready(ready3),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rspv3), .rsp_rdata(rdata3), .rsp_err(err3),
        .sp_en(spen3), .sp_write(spw3), .sp_addr(spa3), .sp_len(spl3), .sp_wdata(spwd3),
        .sp_rdata(sp_rdata));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [63:0] a, input logic [1:0] l,
                           input logic w, input logic [63:0] d);
        req_addr[r*64 +: 64]  = a;
        req_len[r*2 +: 2]     = l;
        req_write[r]          = w;
        req_wdata[r*64 +: 64] = d;
    endtask

    task automatic illegal(input string tag, input logic [63:0] a, input logic [1:0] l);
        set_req(0, a, l, 1'b0, 64'd0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk({tag, "_rspv"}, 64'(rspv1), 64'h1);
        chk({tag, "_err"},  64'(err1),  64'h1);
        chk({tag, "_spen"}, 64'(spen1), 64'h0);
        chk({tag, "_rdata"}, rdata1,    64'h0);
        step();
        chk({tag, "_spen2"}, 64'(spen1), 64'h0);
        chk({tag, "_rspv2"}, 64'(rspv1), 64'h0);
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        sp_rdata = 64'hDEADBEEF_CAFEF00D;
        repeat (2) step();

        // reset state: ready suppressed even with requests pending
        req_valid = 2'b11;
        #1;
        chk("rst_ready1", 64'(ready1), 64'h0);
        chk("rst_ready3", 64'(ready3), 64'h0);
        chk("rst_spen",   64'(spen1),  64'h0);
        chk("rst_rspv",   64'(rspv1),  64'h0);
        chk("rst_rdata",  rdata1,      64'h0);
        req_valid = 2'b00;
        step();

        // single word read at base
        rst = 1'b0;
        set_req(0, 64'd16, 2'b10, 1'b0, 64'd0);
        req_valid = 2'b01;
        #1;
        chk("rd_ready", 64'(ready1), 64'h1);
        step();
        req_valid = 2'b00;
        chk("rd_spen",  64'(spen1),  64'h1);
        chk("rd_spa",   spa1,        64'd16);
        chk("rd_spl",   64'(spl1),   64'h2);
        chk("rd_spw",   64'(spw1),   64'h0);
        chk("rd_ready_busy", 64'(ready1), 64'h0);
        step();
        chk("rd_wait_spen", 64'(spen1), 64'h0);
        chk("rd_wait_rspv", 64'(rspv1), 64'h0);
        step();
        chk("rd_rspv",  64'(rspv1), 64'h1);
        chk("rd_rdata", rdata1,     64'h00000000_CAFEF00D);
        chk("rd_err",   64'(err1),  64'h0);
        step();
        chk("rd_rspv_off", 64'(rspv1), 64'h0);

        // byte read masking
        sp_rdata = 64'hFFFF_FFFF_FFFF_FFA5;
        set_req(0, 64'd18, 2'b00, 1'b0, 64'd0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("byte_rspv",  64'(rspv1), 64'h1);
        chk("byte_rdata", rdata1,     64'h00000000_000000A5);
        step();

        // range / alignment
        illegal("below_base", 64'd15, 2'b00);
        illegal("past_end",   64'd20, 2'b11);
        illegal("misalign",   64'd17, 2'b01);

        set_req(0, 64'd23, 2'b00, 1'b0, 64'd0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("last_spen", 64'(spen1), 64'h1);
        chk("last_spa",  spa1,       64'd23);
        step();
        step();
        chk("last_rspv", 64'(rspv1), 64'h1);
        chk("last_err",  64'(err1),  64'h0);
        chk("last_rdata", rdata1,    64'h00000000_000000A5);
        step();

        // write from requester 1
        set_req(1, 64'd20, 2'b10, 1'b1, 64'h12345678);
        req_valid = 2'b10;
        #1;
        chk("wr_ready", 64'(ready1), 64'h2);
        step();
        req_valid = 2'b00;
        chk("wr_spen",  64'(spen1), 64'h1);
        chk("wr_spw",   64'(spw1),  64'h1);
        chk("wr_spwd",  spwd1,      64'h12345678);
        chk("wr_spl",   64'(spl1),  64'h2);
        chk("wr_spa",   spa1,       64'd20);
        step();
        step();
        chk("wr_rspv",  64'(rspv1), 64'h2);
        chk("wr_rdata", rdata1,     64'h0);
        chk("wr_err",   64'(err1),  64'h0);
        step();

        // contention from reset release: grants alternate every 4 cycles
        rst = 1'b1;
        set_req(0, 64'd16, 2'b10, 1'b0, 64'd0);
        set_req(1, 64'd20, 2'b10, 1'b0, 64'd0);
        req_valid = 2'b11;
        step();
        rst = 1'b0;
        #1;
        chk("ct_ready_c0", 64'(ready1), 64'h1);
        for (int c = 1; c <= 16; c++) begin
            logic [1:0] owner;
            owner = ((c / 4) % 2 == 1) ? 2'b10 : 2'b01;
            step();
            chk($sformatf("ct_rspv_c%0d", c), 64'(rspv1),
                (c % 4 == 3) ? 64'(((((c - 3) / 4) % 2) == 1) ? 2'b10 : 2'b01) : 64'h0);
            chk($sformatf("ct_ready_c%0d", c), 64'(ready1),
                (c % 4 == 0) ? 64'(owner) : 64'h0);
        end
        req_valid = 2'b00;
        rst = 1'b1;
        step();

        // reset during WAIT on the RD_LATENCY=3 instance
        sp_rdata = 64'hDEADBEEF_CAFEF00D;
        rst3 = 1'b0;
        set_req(0, 64'd16, 2'b10, 1'b0, 64'd0);
        req_valid = 2'b01;
        #1;
        chk("rr_ready3", 64'(ready3), 64'h1);
        step();
        req_valid = 2'b00;
        chk("rr_spen3", 64'(spen3), 64'h1);
        step();
        chk("rr_wait_spen3", 64'(spen3), 64'h0);
        step();
        #2;
        rst3 = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rr_async_spen",  64'(spen3),  64'h0);
        chk("rr_async_rspv",  64'(rspv3),  64'h0);
        chk("rr_async_ready", 64'(ready3), 64'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("rr_hold_rspv_c%0d", c), 64'(rspv3), 64'h0);
        end
        rst3 = 1'b0;
        #1;
        chk("rr_post_ready", 64'(ready3), 64'h1);
        step();
        req_valid = 2'b00;
        chk("rr_post_spen", 64'(spen3), 64'h1);
        chk("rr_post_spa",  spa3,       64'd16);
        step();
        step();
        step();
        chk("rr_post_rspv_early", 64'(rspv3), 64'h0);
        step();
        chk("rr_post_rspv",  64'(rspv3), 64'h1);
        chk("rr_post_rdata", rdata3,     64'h00000000_CAFEF00D);
        step();
        chk("rr_post_rspv_off", 64'(rspv3), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
